dpram_stream_reader: RTL and testbench

Read-side controller for the team's simple dual-port block RAM: it drives the RAM's read address and turns the registered, one-cycle-latency read data into a valid/ready stream. It sits on the RAM's read-clock side and drains a commanded block of consecutive words (base, length) to a downstream consumer under full backpressure. The write side is untouched and owned by the producer on the write clock.

---
 rtl/dpram_stream_pkg.sv | 25 ++
 rtl/dpram_rd_fifo.sv | 67 ++++++
 rtl/dpram_stream_reader.sv | 133 +++++++++++++
 tb/tb_dpram_stream_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_stream_pkg.sv
// dpram_stream_pkg
// Shared constants and types for the dual-port RAM stream reader:
//   FIFO_DEPTH - output buffer depth, which also bounds the reads outstanding
//   PTR_W      - FIFO pointer width
//   CNT_W      - FIFO occupancy counter width (must be able to represent "full")
//   state_e    - command FSM states
package dpram_stream_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = occ_width(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/dpram_rd_fifo.sv
// dpram_rd_fifo
// Small first-word-fall-through FIFO that buffers RAM read data for the stream.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    write side (caller guarantees no push into a full FIFO
//                     unless a pop happens in the same cycle)
//   pop_i             read side; ignored while empty
//   data_o, valid_o   head word and its valid flag (combinational from head)
//   count_o           current occupancy
module dpram_rd_fifo
  import dpram_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
  end

  // Storage is reset so the head reads as zero straight out of reset.
  // When full with simultaneous push/pop, the write lands on the slot
  // being popped at the same edge, which is safe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (count_q == CNT_W'(FIFO_DEPTH)) && !pop_i));

endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader
// Drains a block of consecutive RAM words (base_addr, length) into a
// valid/ready stream, tolerating arbitrary backpressure.
// Ports:
//   rclk, rst_n       read clock (shared with RAM read port), async active-low reset
//   start             command strobe, ignored while busy
//   base_addr, length first address and word count of the command
//   busy, done        command in progress / one-cycle completion pulse
//   raddr, ram_dout   RAM read address (registered) and its 1-cycle-late data
//   m_valid, m_ready, m_data  output stream
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data
);

  localparam logic [CNT_W:0]      DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [addr_width:0] LEN_ONE   = (addr_width + 1)'(1);

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width:0]   rem_q, rem_d;
  logic [addr_width-1:0] raddr_q, raddr_d;
  logic [1:0]            tag_q, tag_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic                  credit;
  logic                  pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occ_total;

  // tag_q[0]: raddr holds an issued address; tag_q[1]: ram_dout holds its data.
  assign occ_total = {1'b0, fifo_count} + (CNT_W + 1)'(tag_q[0]) + (CNT_W + 1)'(tag_q[1]);
  assign credit    = (occ_total < DEPTH_LIM);
  assign pop       = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            // The first read goes out on the accepting edge; FIFO and
            // pipeline are empty in IDLE, so credit is guaranteed.
            raddr_d = base_addr;
            addr_d  = base_addr + 1'b1;
            rem_d   = length - 1'b1;
            issue   = 1'b1;
            state_d = (length == LEN_ONE) ? DRAIN : ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          raddr_d = addr_q;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          issue   = 1'b1;
          if (rem_q == LEN_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish on the edge that empties the FIFO with nothing left in flight.
        if ((tag_q == 2'b00) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    tag_d = {tag_q[0], issue};
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      raddr_q <= '0;
      tag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      raddr_q <= raddr_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
    end
  end

  dpram_rd_fifo #(
    .DATA_W(data_width)
  ) u_fifo (
    .clk_i   (rclk),
    .rst_ni  (rst_n),
    .push_i  (tag_q[1]),
    .data_i  (ram_dout),
    .pop_i   (m_ready),
    .data_o  (m_data),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign raddr = raddr_q;

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;

  logic       rclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic [7:0] raddr;
  logic [7:0] ram_dout;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  // Simple dual-port RAM, write clock tied to rclk, registered read.
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic [7:0] mem [256];

  always @(posedge rclk) begin
    if (we) mem[waddr] <= wdata;
    ram_dout <= mem[raddr];
  end

  always #5 rclk = ~rclk;

  dpram_stream_reader #(
    .addr_width(8),
    .data_width(8)
  ) dut (
    .rclk      (rclk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  // Issue a command; returns one cycle after the accepting edge.
  task automatic start_cmd(input logic [7:0] b, input logic [8:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    step();
    start = 1'b0;
    $display("[TB] start base=0x%02h len=%0d", b, l);
  endtask

  // mode 0: ready always high; mode 1: low for 10 cycles then 1,0,0,1 repeating
  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (cyc < 10) return 1'b0;
    return ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endfunction

  // Consume one command's stream. cyc counts cycles since the accepting edge
  // (cyc 0 = cycle right after it). Returns while done is high (no step taken).
  task automatic stream(input logic [7:0] first, input int n, input int mode,
                        input int offset, input int budget, output int first_valid);
    int         got;
    int         cyc;
    int         last_hs;
    int         k;
    bit         fin;
    logic [7:0] exp_w;
    logic [7:0] exp_a;
    got = 0; cyc = offset; last_hs = -1; first_valid = -1; fin = 1'b0;
    while (!fin && cyc < budget) begin
      m_ready = ready_pat(mode, cyc);
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (mode == 0 && n > 0 && !done) begin
        k = (cyc < n - 1) ? cyc : n - 1;
        exp_a = first + 8'(k);
        check("raddr", 32'(raddr), 32'(exp_a));
      end
      if (mode == 1 && cyc == 9) begin
        exp_a = first + 8'd3;
        check("stall_raddr", 32'(raddr), 32'(exp_a));
        check("stall_valid", 32'(m_valid), 32'd1);
      end
      if (done) begin
        check("done_time", 32'(cyc), 32'(last_hs + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        check("word_count", 32'(got), 32'(n));
        fin = 1'b1;
      end else begin
        if (m_valid) begin
          if (got < n) begin
            exp_w = first + 8'(got);
            check("m_data", 32'(m_data), 32'(exp_w));
            if (m_ready) begin
              $display("[TB] word %0d data=0x%02h cyc=%0d", got, m_data, cyc);
              got++;
              last_hs = cyc;
            end
          end else begin
            check("extra_valid", 32'(m_valid), 32'd0);
          end
        end
        step();
        cyc++;
      end
    end
    check("done_seen", 32'(fin), 32'd1);
  endtask

  int fv;
  int hs;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    step(); step();
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_raddr",   32'(raddr),   32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    rst_n = 1'b1;

    // Preload mem[i] = i through the write port.
    for (int i = 0; i < 256; i++) begin
      we = 1'b1; waddr = 8'(i); wdata = 8'(i);
      step();
    end
    we = 1'b0;
    step();

    // Basic 4-word read, ready held high.
    start_cmd(8'h10, 9'd4);
    check("s1_busy", 32'(busy), 32'd1);
    stream(8'h10, 4, 0, 0, 40, fv);
    check("s1_first_valid", 32'(fv), 32'd2);
    step();

    // Address wrap 0xFE -> 0x01.
    start_cmd(8'hFE, 9'd4);
    stream(8'hFE, 4, 0, 0, 40, fv);
    check("s2_first_valid", 32'(fv), 32'd2);
    step();

    // Backpressure: held low 10 cycles, then 1,0,0,1 pattern.
    start_cmd(8'h50, 9'd8);
    stream(8'h50, 8, 1, 0, 200, fv);
    m_ready = 1'b1;
    step();

    // Zero-length command: done next cycle, no words.
    start_cmd(8'h33, 9'd0);
    stream(8'h33, 0, 0, 0, 10, fv);
    check("len0_no_valid", 32'(fv), 32'hFFFF_FFFF);
    step();

    // Start while busy is ignored.
    start_cmd(8'h20, 9'd3);
    base_addr = 8'h80; length = 9'd5; start = 1'b1;
    step();
    start = 1'b0;
    stream(8'h20, 3, 0, 1, 40, fv);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ignored_valid", 32'(m_valid), 32'd0);
      check("ignored_busy",  32'(busy),    32'd0);
    end

    // Reset mid-command after 3 accepted words.
    start_cmd(8'h10, 9'd8);
    m_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 20 && hs < 3; i++) begin
      if (m_valid && m_ready) hs++;
      step();
    end
    check("rst_mid_words", 32'(hs), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",    32'(busy),    32'd0);
    check("rst_mid_valid",   32'(m_valid), 32'd0);
    check("rst_mid_raddr",   32'(raddr),   32'd0);
    check("rst_mid_done",    32'(done),    32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_done",  32'(done),    32'd0);
      check("post_rst_valid", 32'(m_valid), 32'd0);
    end
    start_cmd(8'h10, 9'd4);
    stream(8'h10, 4, 0, 0, 40, fv);
    check("s5_first_valid", 32'(fv), 32'd2);
    step();

    // Back-to-back: new start issued in the done cycle.
    start_cmd(8'h30, 9'd3);
    stream(8'h30, 3, 0, 0, 40, fv);
    start_cmd(8'h40, 9'd2);
    stream(8'h40, 2, 0, 0, 40, fv);
    check("b2b_first_valid", 32'(fv), 32'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
